// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter: requester ids, arbiter
// states, the read-tag record and a saturating counter helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    REQ_F = 2'd0,
    REQ_D = 2'd1,
    REQ_L = 2'd2
  } req_id_e;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

  localparam int RD_LAT_MAX = 3;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rd_tag_pipe.sv
// RD_LAT-stage shift register of read tags; the tail is decoded into a
// one-hot read-valid vector indexed by requester id ({L, D, F}).
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid_i,
  input  req_id_e    push_id_i,
  output logic [2:0] rvalid_o
);

  rd_tag_t tag_d;
  rd_tag_t tag_q [RD_LAT];

  assign tag_d = '{valid: push_valid_i, id: push_id_i};

  // NOTE: the tag stages are reset (not just their inputs) so that a reset
  // drops every in-flight read; non-blocking assignments keep the shift order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (tag_q[RD_LAT-1].valid) begin
      case (tag_q[RD_LAT-1].id)
        REQ_F:   rvalid_o[0] = 1'b1;
        REQ_D:   rvalid_o[1] = 1'b1;
        REQ_L:   rvalid_o[2] = 1'b1;
        default: rvalid_o    = '0;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for fetch, data and loader ports with loader lock
// and read-data routing. Define RAM_ARB_PERF_EN to add grant counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1   // legal 1..RD_LAT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       perf_f_cnt,
  output logic [15:0]       perf_d_cnt,
  output logic [15:0]       perf_l_cnt
`endif
);

  arb_state_e        state_q, state_d;
  req_id_e           rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              f_sel, d_sel, l_sel;
  logic              push_valid;
  req_id_e           push_id;
  logic [2:0]        rvalid;

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    f_sel   = 1'b0;
    d_sel   = 1'b0;
    l_sel   = 1'b0;
    case (state_q)
      ARB: begin
        if (l_req) begin
          l_sel = 1'b1;
          if (l_lock) state_d = LOCKED;
        end else if (f_req && (!d_req || rr_q == REQ_F)) begin
          f_sel = 1'b1;
          rr_d  = REQ_D;
        end else if (d_req) begin
          d_sel = 1'b1;
          rr_d  = REQ_F;
        end
      end
      LOCKED: begin
        // The unlock cycle itself issues no grant.
        if (!l_lock)    state_d = ARB;
        else if (l_req) l_sel   = 1'b1;
      end
      default: state_d = ARB;
    endcase
    if (reset) begin
      f_sel = 1'b0;
      d_sel = 1'b0;
      l_sel = 1'b0;
    end
  end

  // Idle cycles keep the last address/data on the RAM bus.
  always_comb begin
    ram_en = f_sel | d_sel | l_sel;
    ram_we = (d_sel & d_we) | (l_sel & l_we);
    if (f_sel)      ram_addr = f_addr;
    else if (d_sel) ram_addr = d_addr;
    else if (l_sel) ram_addr = l_addr;
    else            ram_addr = addr_q;
    if (d_sel)      ram_wdata = d_wdata;
    else if (l_sel) ram_wdata = l_wdata;
    else            ram_wdata = wdata_q;
  end

  assign addr_d     = ram_addr;
  assign wdata_d    = ram_wdata;
  assign push_valid = ram_en & ~ram_we;
  assign push_id    = f_sel ? REQ_F : (d_sel ? REQ_D : REQ_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      rr_q    <= REQ_F;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (push_valid),
    .push_id_i    (push_id),
    .rvalid_o     (rvalid)
  );

  assign f_gnt    = f_sel;
  assign d_gnt    = d_sel;
  assign l_gnt    = l_sel;
  assign f_rvalid = rvalid[0];
  assign d_rvalid = rvalid[1];
  assign l_rvalid = rvalid[2];
  assign rd_data  = (|rvalid) ? ram_rdata : '0;

`ifdef RAM_ARB_PERF_EN
  logic [15:0] perf_f_q, perf_d_q, perf_l_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_f_q <= '0;
      perf_d_q <= '0;
      perf_l_q <= '0;
    end else if (perf_clr) begin
      perf_f_q <= '0;
      perf_d_q <= '0;
      perf_l_q <= '0;
    end else begin
      if (f_sel) perf_f_q <= sat_inc16(perf_f_q);
      if (d_sel) perf_d_q <= sat_inc16(perf_d_q);
      if (l_sel) perf_l_q <= sat_inc16(perf_l_q);
    end
  end

  assign perf_f_cnt = perf_f_q;
  assign perf_d_cnt = perf_d_q;
  assign perf_l_cnt = perf_l_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table for grants/RAM command, a RAM model,
// and a read-data scoreboard checked by a monitor on the falling edge.
module tb_ram_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 1;

  logic          clk, reset;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
`ifdef RAM_ARB_PERF_EN
  logic          perf_clr;
  logic [15:0]   perf_f_cnt, perf_d_cnt, perf_l_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .rd_data(rd_data), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef RAM_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_f_cnt(perf_f_cnt),
    .perf_d_cnt(perf_d_cnt), .perf_l_cnt(perf_l_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 16'h1234 : (16'hA000 | DW'(a));
  endfunction

  // RAM model: reloads its initial image on reset, sync read of LAT cycles.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign ram_rdata = rd_pipe[LAT-1];

  // Expected RAM contents as the bench believes them to be.
  logic [DW-1:0] shadow [256];

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    int            due;
  } exp_rd_t;
  exp_rd_t sb_q[$];

  typedef struct {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          l_req, l_we, l_lock;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [2:0]    exp_gnt;   // {l, d, f}
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic          chk_wd;
    logic [DW-1:0] exp_wd;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(
    input logic fr, input logic [AW-1:0] fa,
    input logic dr, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
    input logic lr, input logic lwe, input logic lk, input logic [AW-1:0] la,
    input logic [DW-1:0] lwd, input logic [2:0] g, input logic we,
    input logic [AW-1:0] ea, input logic cw, input logic [DW-1:0] ewd);
    vec_t t;
    t.f_req = fr;  t.f_addr = fa;
    t.d_req = dr;  t.d_we = dwe; t.d_addr = da; t.d_wdata = dwd;
    t.l_req = lr;  t.l_we = lwe; t.l_lock = lk; t.l_addr = la; t.l_wdata = lwd;
    t.exp_gnt = g; t.exp_we = we; t.exp_addr = ea; t.chk_wd = cw; t.exp_wd = ewd;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    f_req = 0; f_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    l_req = 0; l_we = 0; l_lock = 0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic push_rd(input logic [1:0] id, input logic [AW-1:0] a);
    exp_rd_t e;
    e.id = id; e.data = shadow[a]; e.due = cyc_cnt + LAT;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " gnt"},     32'({l_gnt, d_gnt, f_gnt}), 32'd0);
    check({nm, " rvalid"},  32'({l_rvalid, d_rvalid, f_rvalid}), 32'd0);
    check({nm, " ram_en"},  32'(ram_en), 32'd0);
    check({nm, " ram_we"},  32'(ram_we), 32'd0);
    check({nm, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({nm, " ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({nm, " rd_data"}, 32'(rd_data), 32'd0);
  endtask

  // Assert reset with idle inputs, check reset values, release after a cycle.
  task automatic do_reset(input string nm);
    reset = 1'b1;
    drive_idle();
    sb_q.delete();
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    @(negedge clk);
    check_reset_outputs(nm);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    f_req = t.f_req; f_addr = t.f_addr;
    d_req = t.d_req; d_we = t.d_we; d_addr = t.d_addr; d_wdata = t.d_wdata;
    l_req = t.l_req; l_we = t.l_we; l_lock = t.l_lock; l_addr = t.l_addr; l_wdata = t.l_wdata;
    @(negedge clk);
    check({nm, " gnt{l,d,f}"}, 32'({l_gnt, d_gnt, f_gnt}), 32'(t.exp_gnt));
    check({nm, " ram_en"},     32'(ram_en), 32'(|t.exp_gnt));
    check({nm, " ram_we"},     32'(ram_we), 32'(t.exp_we));
    check({nm, " ram_addr"},   32'(ram_addr), 32'(t.exp_addr));
    if (t.chk_wd) check({nm, " ram_wdata"}, 32'(ram_wdata), 32'(t.exp_wd));
    if (t.exp_gnt[0]) push_rd(2'd0, t.f_addr);
    if (t.exp_gnt[1]) begin
      if (t.d_we) shadow[t.d_addr] = t.d_wdata;
      else        push_rd(2'd1, t.d_addr);
    end
    if (t.exp_gnt[2]) begin
      if (t.l_we) shadow[t.l_addr] = t.l_wdata;
      else        push_rd(2'd2, t.l_addr);
    end
    @(posedge clk); #1;
  endtask

  // Read-return monitor: every rvalid must match the oldest expectation.
  logic [2:0] mon_rv;
  exp_rd_t    mon_e;
  always @(negedge clk) begin
    mon_rv = {l_rvalid, d_rvalid, f_rvalid};
    if (mon_rv != 3'b000) begin
      if (sb_q.size() == 0) begin
        check("unexpected rvalid", 32'(mon_rv), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rvalid onehot{l,d,f}", 32'(mon_rv), 32'(3'b001 << mon_e.id));
        check("rd_data", 32'(rd_data), 32'(mon_e.data));
        check("rvalid cycle", mon_e.due, cyc_cnt);
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive_idle();
`ifdef RAM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    //          f  fa     d  we da     dwd       l  we lk la     lwd       gnt  we addr   cw wd
    vecs.push_back(mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h01, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 0, 8'h02, 1, 16'h0000));
    vecs.push_back(mk(1, 8'h03, 1, 1, 8'h10, 16'h5555, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h03, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h03, 1, 1, 8'h10, 16'h5555, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 1, 8'h10, 1, 16'h5555));
    vecs.push_back(mk(1, 8'h05, 1, 0, 8'h10, 16'h0BAD, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h05, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h05, 1, 0, 8'h10, 16'h0BAD, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 0, 8'h10, 1, 16'h0BAD));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b000, 0, 8'h10, 1, 16'h0BAD));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h02, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 0, 8'h02, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h01, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 0, 8'h01, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h03, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h03, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h20, 16'h7777, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 1, 8'h20, 1, 16'h7777));
    vecs.push_back(mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, 1, 0, 0, 8'h07, 16'h0000, 3'b100, 0, 8'h07, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h01, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 0, 8'h02, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 16'h0000, 1, 1, 1, 8'h04, 16'h8004, 3'b100, 1, 8'h04, 1, 16'h8004));
    vecs.push_back(mk(1, 8'h05, 1, 0, 8'h02, 16'h0000, 1, 1, 1, 8'h00, 16'h0102, 3'b100, 1, 8'h00, 1, 16'h0102));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 8'h00, 16'h0000, 3'b000, 0, 8'h00, 1, 16'h0102));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b000, 0, 8'h00, 1, 16'h0102));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h05, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h04, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 0, 8'h04, 0, 16'h0000));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 16'h0000, 3'b100, 0, 8'h00, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h03, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h04, 16'h0000, 3'b100, 0, 8'h04, 0, 16'h0000));
    vecs.push_back(mk(1, 8'h03, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h03, 0, 16'h0000));

    do_reset("reset");
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));
    drive_idle();
    repeat (3) @(posedge clk);
    #1;

    // Data load granted, then reset before its read returns.
    d_req = 1; d_we = 0; d_addr = 8'h04;
    @(negedge clk);
    check("midreset d_gnt", 32'(d_gnt), 32'd1);
    #1;
    do_reset("midreset");
    repeat (3) run_vec(mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000,
                          3'b000, 0, 8'h00, 1, 16'h0000), "post-midreset idle");

    // Reset while LOCKED with rr_ptr on DATA and a loader read in flight.
    run_vec(mk(1, 8'h03, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h03, 0, 16'h0000), "lk f");
    run_vec(mk(0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1, 1, 8'h09, 16'h4242, 3'b100, 1, 8'h09, 1, 16'h4242), "lk wr");
    l_req = 1; l_we = 0; l_lock = 1; l_addr = 8'h09;
    @(negedge clk);
    check("lk rd l_gnt", 32'(l_gnt), 32'd1);
    #1;
    do_reset("lockreset");
    run_vec(mk(1, 8'h06, 1, 0, 8'h07, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h06, 0, 16'h0000), "after lockreset f");
    run_vec(mk(1, 8'h06, 1, 0, 8'h07, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b010, 0, 8'h07, 0, 16'h0000), "after lockreset d");

`ifdef RAM_ARB_PERF_EN
    do_reset("perf reset");
    check("perf reset f", 32'(perf_f_cnt), 32'd0);
    for (int i = 0; i < 4; i++)
      run_vec(mk(1, 8'h01, 1, 0, 8'h02, 16'h0000, 0, 0, 0, 8'h00, 16'h0000,
                 (i % 2 == 0) ? 3'b001 : 3'b010, 0, (i % 2 == 0) ? 8'h01 : 8'h02,
                 0, 16'h0000), $sformatf("perf p%0d", i));
    run_vec(mk(1, 8'h03, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h03, 0, 16'h0000), "perf p4");
    drive_idle();
    @(negedge clk);
    check("perf_f_cnt", 32'(perf_f_cnt), 32'd3);
    check("perf_d_cnt", 32'(perf_d_cnt), 32'd2);
    check("perf_l_cnt", 32'(perf_l_cnt), 32'd0);
    @(posedge clk); #1;
    perf_clr = 1'b1;
    run_vec(mk(1, 8'h03, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 3'b001, 0, 8'h03, 0, 16'h0000), "perf clr");
    perf_clr = 1'b0;
    drive_idle();
    @(negedge clk);
    check("perf_f_cnt clr", 32'(perf_f_cnt), 32'd0);
    check("perf_d_cnt clr", 32'(perf_d_cnt), 32'd0);
    check("perf_l_cnt clr", 32'(perf_l_cnt), 32'd0);
    @(posedge clk); #1;
`endif

    drive_idle();
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("scoreboard drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
